// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the character-LCD controller:
//   - lcd_state_t   : controller FSM states
//   - TIMER_W       : width of every wait counter
//   - DEF_*         : default timing constants in clock cycles at 50 MHz
//   - CFG_SEQ       : configuration bytes sent after the init nibbles
//   - cfg_nibble()  : selects one nibble of the configuration sequence
//   - step_nibble() : nibble sent at a given init/config step
//   - wait_last()   : terminal count for a wait (a wait of 0 lasts one cycle)
// -----------------------------------------------------------------------------
package lcd_pkg;

   localparam int unsigned TIMER_W = 20;

   localparam int unsigned DEF_CLK_HZ  = 50_000_000;
   localparam int unsigned DEF_T_PWR   = 750_000;   // 15 ms
   localparam int unsigned DEF_T_4MS   = 205_000;   // 4.1 ms
   localparam int unsigned DEF_T_100US = 5_000;     // 100 us
   localparam int unsigned DEF_T_40US  = 2_000;     // 40 us
   localparam int unsigned DEF_T_CLR   = 82_000;    // 1.64 ms
   localparam int unsigned DEF_T_1US   = 50;        // 1 us
   localparam int unsigned DEF_T_SU    = 2;         // RS/data setup before E
   localparam int unsigned DEF_T_E     = 12;        // E high width

   typedef enum logic [2:0] {
      ST_WAIT_PWR,
      ST_SETUP,
      ST_PULSE,
      ST_GAP,
      ST_READY
   } lcd_state_t;

   // Function set 4-bit/2-line, entry mode inc, display on, clear display.
   localparam logic [31:0] CFG_SEQ = 32'h28_06_0C_01;

   // Step numbering: 0..3 init nibbles, 4..11 config nibbles, 12 host traffic.
   localparam logic [3:0] LAST_STEP = 4'd11;
   localparam logic [3:0] HOST_STEP = 4'd12;

   // idx 0 is the high nibble of the first byte; {~idx,2'b00} == 4*(7-idx).
   function automatic logic [3:0] cfg_nibble(input logic [2:0] idx);
      logic [31:0] shifted;
      shifted = CFG_SEQ >> {~idx, 2'b00};
      return shifted[3:0];
   endfunction

   function automatic logic [3:0] step_nibble(input logic [3:0] step);
      if (step < 4'd3) begin
         return 4'h3;
      end else if (step == 4'd3) begin
         return 4'h2;
      end else begin
         return cfg_nibble(3'(step - 4'd4));
      end
   endfunction

   function automatic logic [TIMER_W-1:0] wait_last(input logic [TIMER_W-1:0] value);
      return (value == '0) ? '0 : value - 1'b1;
   endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// -----------------------------------------------------------------------------
// lcd_delay_timer
// One-shot cycle counter. A start pulse loads a wait length; o_done is high
// in the last cycle of the wait, counting the start cycle as cycle 0, so a
// state that starts the timer on entry and leaves on o_done lasts exactly
// i_load cycles (a load of 0 behaves as 1).
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   i_start  : one-cycle pulse, begins a wait of i_load cycles
//   i_load   : wait length in cycles
//   o_done   : high in the final cycle of the wait
// -----------------------------------------------------------------------------
module lcd_delay_timer
   import lcd_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [TIMER_W-1:0] i_load,
   output logic               o_done
);

   logic [TIMER_W-1:0] r_count;
   logic [TIMER_W-1:0] r_last;
   logic               r_run;

   logic [TIMER_W-1:0] w_count;
   logic [TIMER_W-1:0] w_last;

   // The start cycle is already count 0, so compare against the incoming
   // load directly instead of waiting for it to be registered.
   assign w_count = i_start ? '0 : r_count;
   assign w_last  = i_start ? wait_last(i_load) : r_last;
   assign o_done  = (i_start | r_run) && (w_count == w_last);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_last  <= '0;
         r_run   <= 1'b0;
      end else if (i_start) begin
         r_count <= TIMER_W'(1);
         r_last  <= w_last;
         r_run   <= ~o_done;
      end else if (r_run) begin
         r_count <= r_count + 1'b1;
         if (o_done) begin
            r_run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/lcd_controller.sv
// -----------------------------------------------------------------------------
// lcd_controller
// 4-bit HD44780-style LCD driver. After reset it waits for power-up, sends
// the 0x3/0x3/0x3/0x2 wake-up nibbles and the configuration bytes, then
// accepts host nibbles (RS=1) one at a time, alternating high/low nibble.
// Ports:
//   clk                     : clock, rising edge
//   iLCD_reset              : asynchronous active-low reset
//   iLCD_data[3:0]          : host nibble
//   iLCD_writeEN            : host write strobe, honoured only when ready
//   oLCD_response           : high while ready to accept a nibble
//   oLCD_Data[3:0]          : LCD DB7..DB4
//   oLCD_Enabled            : LCD E
//   oLCD_RegisterSelect     : LCD RS (0 command, 1 data)
//   oLCD_ReadWrite          : LCD R/W, tied low (write only)
//   oLCD_StrataFlashControl : tied high to keep the shared flash disabled
// -----------------------------------------------------------------------------
module lcd_controller
   import lcd_pkg::*;
#(
   parameter int unsigned CLK_HZ  = DEF_CLK_HZ,
   parameter int unsigned T_PWR   = DEF_T_PWR,
   parameter int unsigned T_4MS   = DEF_T_4MS,
   parameter int unsigned T_100US = DEF_T_100US,
   parameter int unsigned T_40US  = DEF_T_40US,
   parameter int unsigned T_CLR   = DEF_T_CLR,
   parameter int unsigned T_1US   = DEF_T_1US,
   parameter int unsigned T_SU    = DEF_T_SU,
   parameter int unsigned T_E     = DEF_T_E
)(
   input  logic       clk,
   input  logic       iLCD_reset,
   input  logic [3:0] iLCD_data,
   input  logic       iLCD_writeEN,
   output logic       oLCD_response,
   output logic [3:0] oLCD_Data,
   output logic       oLCD_Enabled,
   output logic       oLCD_RegisterSelect,
   output logic       oLCD_ReadWrite,
   output logic       oLCD_StrataFlashControl
);

   if (CLK_HZ == 0) begin : g_clk_check
      $error("lcd_controller: CLK_HZ must be nonzero");
   end

   localparam logic [TIMER_W-1:0] W_PWR   = TIMER_W'(T_PWR);
   localparam logic [TIMER_W-1:0] W_4MS   = TIMER_W'(T_4MS);
   localparam logic [TIMER_W-1:0] W_100US = TIMER_W'(T_100US);
   localparam logic [TIMER_W-1:0] W_40US  = TIMER_W'(T_40US);
   localparam logic [TIMER_W-1:0] W_CLR   = TIMER_W'(T_CLR);
   localparam logic [TIMER_W-1:0] W_1US   = TIMER_W'(T_1US);
   localparam logic [TIMER_W-1:0] W_SU    = TIMER_W'(T_SU);
   localparam logic [TIMER_W-1:0] W_E     = TIMER_W'(T_E);

   lcd_state_t         r_state;
   logic [3:0]         r_step;
   logic               r_parity;   // 0: next host nibble is a high nibble
   logic [3:0]         r_data;
   logic               r_rs;
   logic               r_e;
   logic               r_response;
   logic               r_start;
   logic [TIMER_W-1:0] r_load;

   logic [TIMER_W-1:0] w_gap;
   logic               w_done;

   lcd_delay_timer u_timer (
      .clk     (clk),
      .rst_n   (iLCD_reset),
      .i_start (r_start),
      .i_load  (r_load),
      .o_done  (w_done)
   );

   // Gap that follows the nibble currently on the bus.
   always_comb begin
      // NOTE: default assignment first, so no path leaves w_gap unassigned
      // and no latch is inferred.
      w_gap = W_40US;
      if (r_step == HOST_STEP) begin
         w_gap = r_parity ? W_40US : W_1US;
      end else begin
         case (r_step)
            4'd0:       w_gap = W_4MS;
            4'd1:       w_gap = W_100US;
            4'd2, 4'd3: w_gap = W_40US;
            LAST_STEP:  w_gap = W_CLR;
            // Config steps: even step = high nibble of a byte.
            default:    w_gap = r_step[0] ? W_40US : W_1US;
         endcase
      end
   end

   // Every state entry also starts the timer with that state's length.
   always_ff @(posedge clk or negedge iLCD_reset) begin
      if (!iLCD_reset) begin
         r_state    <= ST_WAIT_PWR;
         r_step     <= '0;
         r_parity   <= 1'b0;
         r_data     <= '0;
         r_rs       <= 1'b0;
         r_e        <= 1'b0;
         r_response <= 1'b0;
         // Reset is itself the entry into WAIT_PWR.
         r_start    <= 1'b1;
         r_load     <= W_PWR;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            ST_WAIT_PWR: begin
               if (w_done) begin
                  r_state <= ST_SETUP;
                  r_data  <= step_nibble(r_step);
                  r_rs    <= 1'b0;
                  r_start <= 1'b1;
                  r_load  <= W_SU;
               end
            end
            ST_SETUP: begin
               if (w_done) begin
                  r_state <= ST_PULSE;
                  r_e     <= 1'b1;
                  r_start <= 1'b1;
                  r_load  <= W_E;
               end
            end
            ST_PULSE: begin
               if (w_done) begin
                  r_state <= ST_GAP;
                  r_e     <= 1'b0;
                  r_start <= 1'b1;
                  r_load  <= w_gap;
               end
            end
            ST_GAP: begin
               if (w_done) begin
                  if (r_step == HOST_STEP) begin
                     r_parity   <= ~r_parity;
                     r_state    <= ST_READY;
                     r_response <= 1'b1;
                  end else if (r_step == LAST_STEP) begin
                     r_step     <= HOST_STEP;
                     r_state    <= ST_READY;
                     r_response <= 1'b1;
                  end else begin
                     r_step  <= r_step + 4'd1;
                     r_state <= ST_SETUP;
                     r_data  <= step_nibble(r_step + 4'd1);
                     r_start <= 1'b1;
                     r_load  <= W_SU;
                  end
               end
            end
            ST_READY: begin
               if (iLCD_writeEN) begin
                  r_state    <= ST_SETUP;
                  r_data     <= iLCD_data;
                  r_rs       <= 1'b1;
                  r_response <= 1'b0;
                  r_start    <= 1'b1;
                  r_load     <= W_SU;
               end
            end
            default: begin
               r_state <= ST_WAIT_PWR;
            end
         endcase
      end
   end

   assign oLCD_response           = r_response;
   assign oLCD_Data               = r_data;
   assign oLCD_Enabled            = r_e;
   assign oLCD_RegisterSelect     = r_rs;
   assign oLCD_ReadWrite          = 1'b0;
   assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_controller.sv
// -----------------------------------------------------------------------------
// tb_lcd_controller
// Directed bench for lcd_controller with shortened timing. Outputs are
// sampled on the falling clock edge. A "lead" is the number of low-E samples
// from the current sample up to the sample where E is first seen high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_controller;

   localparam int unsigned P_PWR   = 20;
   localparam int unsigned P_4MS   = 10;
   localparam int unsigned P_100US = 6;
   localparam int unsigned P_40US  = 4;
   localparam int unsigned P_CLR   = 8;
   localparam int unsigned P_1US   = 2;
   localparam int unsigned P_SU    = 2;
   localparam int unsigned P_E     = 12;
   localparam int          BUDGET  = 400;

   // Init + config nibbles and the lead before each pulse.
   // Lead 0: 20 WAIT_PWR + 2 setup cycles counted from the release sample.
   // Later leads: previous gap + 2 setup (gaps 10,6,4,4, then 2/4 per byte).
   localparam logic [3:0] INIT_D    [12] = '{4'h3, 4'h3, 4'h3, 4'h2,
                                             4'h2, 4'h8, 4'h0, 4'h6,
                                             4'h0, 4'hC, 4'h0, 4'h1};
   localparam int         INIT_LEAD [12] = '{22, 12, 8, 6, 6, 4, 6, 4, 6, 4, 6, 4};

   logic       clk = 1'b0;
   logic       iLCD_reset = 1'b0;
   logic [3:0] iLCD_data = 4'h0;
   logic       iLCD_writeEN = 1'b0;
   logic       oLCD_response;
   logic [3:0] oLCD_Data;
   logic       oLCD_Enabled;
   logic       oLCD_RegisterSelect;
   logic       oLCD_ReadWrite;
   logic       oLCD_StrataFlashControl;

   int n_vec     = 0;
   int n_miss    = 0;
   int const_bad = 0;

   always #5 clk = ~clk;

   lcd_controller #(
      .CLK_HZ  (50_000_000),
      .T_PWR   (P_PWR),
      .T_4MS   (P_4MS),
      .T_100US (P_100US),
      .T_40US  (P_40US),
      .T_CLR   (P_CLR),
      .T_1US   (P_1US),
      .T_SU    (P_SU),
      .T_E     (P_E)
   ) dut (
      .clk                     (clk),
      .iLCD_reset              (iLCD_reset),
      .iLCD_data               (iLCD_data),
      .iLCD_writeEN            (iLCD_writeEN),
      .oLCD_response           (oLCD_response),
      .oLCD_Data               (oLCD_Data),
      .oLCD_Enabled            (oLCD_Enabled),
      .oLCD_RegisterSelect     (oLCD_RegisterSelect),
      .oLCD_ReadWrite          (oLCD_ReadWrite),
      .oLCD_StrataFlashControl (oLCD_StrataFlashControl)
   );

   always @(negedge clk) begin
      if (oLCD_ReadWrite !== 1'b0 || oLCD_StrataFlashControl !== 1'b1) begin
         const_bad++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for the next E pulse, checks its lead, data, RS and width.
   // With poke set, strobes writeEN (data 0x9) while E is high.
   task automatic pulse(input string tag, input logic [3:0] exp_d, input logic exp_rs,
                        input int exp_lead, input bit poke);
      int lead;
      int width;
      lead  = 0;
      width = 0;
      while (oLCD_Enabled !== 1'b1 && lead < BUDGET) begin
         lead++;
         @(negedge clk);
      end
      check({tag, "_lead"}, lead, exp_lead);
      check({tag, "_data"}, oLCD_Data, exp_d);
      check({tag, "_rs"}, oLCD_RegisterSelect, exp_rs);
      check({tag, "_resp"}, oLCD_response, 1'b0);
      while (oLCD_Enabled === 1'b1 && width < BUDGET) begin
         if (poke && width == 3) begin
            iLCD_writeEN = 1'b1;
            iLCD_data    = 4'h9;
         end else if (poke && width == 4) begin
            iLCD_writeEN = 1'b0;
         end
         width++;
         @(negedge clk);
      end
      check({tag, "_width"}, width, P_E);
   endtask

   // From the sample where E fell, counts samples until response rises.
   task automatic await_ready(input string tag, input int exp_gap);
      int gap;
      gap = 0;
      while (oLCD_response !== 1'b1 && oLCD_Enabled !== 1'b1 && gap < BUDGET) begin
         gap++;
         @(negedge clk);
      end
      check({tag, "_gap"}, gap, exp_gap);
      check({tag, "_ready"}, oLCD_response, 1'b1);
   endtask

   task automatic host_write(input logic [3:0] d);
      iLCD_writeEN = 1'b1;
      iLCD_data    = d;
      @(negedge clk);
      iLCD_writeEN = 1'b0;
      check("resp_fall", oLCD_response, 1'b0);
   endtask

   task automatic run_init(input string pfx);
      for (int i = 0; i < 12; i++) begin
         pulse($sformatf("%s%0d", pfx, i), INIT_D[i], 1'b0, INIT_LEAD[i], 1'b0);
      end
      await_ready({pfx, "clr"}, P_CLR);
   endtask

   initial begin
      int hi;
      int waited;

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_resp", oLCD_response, 1'b0);
      check("rst_e",    oLCD_Enabled, 1'b0);
      check("rst_data", oLCD_Data, 4'h0);
      check("rst_rs",   oLCD_RegisterSelect, 1'b0);
      check("rst_rw",   oLCD_ReadWrite, 1'b0);
      check("rst_sf",   oLCD_StrataFlashControl, 1'b1);

      // Phase 1: clean init, then host writes 0x4 (high) and 0x1 (low),
      // with an ignored strobe while the first one is on the bus.
      iLCD_reset = 1'b1;
      run_init("p1_");
      host_write(4'h4);
      pulse("h4", 4'h4, 1'b1, P_SU, 1'b1);
      await_ready("h4", P_1US);
      host_write(4'h1);
      pulse("h1", 4'h1, 1'b1, P_SU, 1'b0);
      await_ready("h1", P_40US);
      hi = 0;
      repeat (30) begin
         @(negedge clk);
         if (oLCD_Enabled === 1'b1) hi++;
      end
      check("no_extra_e", hi, 0);
      check("idle_ready", oLCD_response, 1'b1);

      // Phase 2: strobe held high through reset and init. Nothing is sent
      // before READY; then one nibble per READY cycle, high nibble first.
      // Lead 3 = the READY sample + 2 setup cycles.
      iLCD_reset   = 1'b0;
      iLCD_data    = 4'hF;
      iLCD_writeEN = 1'b1;
      @(negedge clk);
      iLCD_reset = 1'b1;
      run_init("p2_");
      pulse("held0", 4'hF, 1'b1, 3, 1'b0);
      await_ready("held0", P_1US);
      pulse("held1", 4'hF, 1'b1, 3, 1'b0);
      await_ready("held1", P_40US);
      iLCD_writeEN = 1'b0;
      @(negedge clk);
      check("held_stop", oLCD_response, 1'b1);

      // Phase 3: reset while E is high aborts at once; init restarts.
      host_write(4'h5);
      waited = 0;
      while (oLCD_Enabled !== 1'b1 && waited < BUDGET) begin
         waited++;
         @(negedge clk);
      end
      check("p3_e_up", oLCD_Enabled, 1'b1);
      check("p3_data", oLCD_Data, 4'h5);
      repeat (3) @(negedge clk);
      #2;
      iLCD_reset = 1'b0;
      #1;
      check("abort_e",    oLCD_Enabled, 1'b0);
      check("abort_data", oLCD_Data, 4'h0);
      check("abort_rs",   oLCD_RegisterSelect, 1'b0);
      check("abort_resp", oLCD_response, 1'b0);
      @(negedge clk);
      iLCD_reset = 1'b1;
      pulse("p3_0", 4'h3, 1'b0, 22, 1'b0);
      pulse("p3_1", 4'h3, 1'b0, 12, 1'b0);

      check("const_outs", const_bad, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
